// File: rtl/camera_sensor_emulator.sv
// MT9V034-style parallel pixel port generator: FRAME_VALID / LINE_VALID envelope
// with configurable active area and blanking, and selectable 10-bit test patterns.
module camera_sensor_emulator #(
  parameter int unsigned H        = 752,
  parameter int unsigned V        = 480,
  parameter int unsigned H_BLANK  = 94,
  parameter int unsigned FV_LEAD  = 4,
  parameter int unsigned FV_TRAIL = 4,
  parameter int unsigned V_BLANK  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] pattern,
  output logic       frame_valid,
  output logic       line_valid,
  output logic [9:0] data_out,
  output logic       frame_done,
  output logic [9:0] frame_count
);

  localparam int unsigned DW      = 10;
  localparam int unsigned MAX_HV  = (H > V) ? H : V;
  localparam int unsigned MAX_B0  = (H_BLANK > FV_LEAD) ? H_BLANK : FV_LEAD;
  localparam int unsigned MAX_B1  = (FV_TRAIL > V_BLANK) ? FV_TRAIL : V_BLANK;
  localparam int unsigned MAX_B   = (MAX_B0 > MAX_B1) ? MAX_B0 : MAX_B1;
  localparam int unsigned MAX_ALL = (MAX_HV > MAX_B) ? MAX_HV : MAX_B;
  localparam int unsigned PW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;
  localparam int unsigned CW      = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned LW      = (V > 1) ? $clog2(V) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FV_LEAD  = 3'd1,
    S_ACTIVE   = 3'd2,
    S_H_BLANK  = 3'd3,
    S_FV_TRAIL = 3'd4,
    S_V_BLANK  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [CW-1:0]   col_q, col_d;
  logic [LW-1:0]   line_q, line_d;
  logic [1:0]      pat_q, pat_d;

  logic            fv_d, lv_d, done_d;
  logic [DW-1:0]   data_d;
  logic [DW-1:0]   pixel_d;
  logic [DW-1:0]   col_ext, line_ext;

  // State and counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      col_q   <= '0;
      line_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      line_q  <= line_d;
      pat_q   <= pat_d;
    end
  end

  // Next-state and counter update; phase is shared by all blanking intervals
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    line_d  = line_q;
    pat_d   = pat_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_FV_LEAD;
          phase_d = '0;
          col_d   = '0;
          line_d  = '0;
          pat_d   = pattern;
        end
      end
      S_FV_LEAD: begin
        if (phase_q == PW'(FV_LEAD - 1)) begin
          state_d = S_ACTIVE;
          phase_d = '0;
          col_d   = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_ACTIVE: begin
        if (col_q == CW'(H - 1)) begin
          phase_d = '0;
          state_d = (line_q == LW'(V - 1)) ? S_FV_TRAIL : S_H_BLANK;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_H_BLANK: begin
        if (phase_q == PW'(H_BLANK - 1)) begin
          state_d = S_ACTIVE;
          phase_d = '0;
          col_d   = '0;
          line_d  = line_q + LW'(1);
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_FV_TRAIL: begin
        if (phase_q == PW'(FV_TRAIL - 1)) begin
          state_d = S_V_BLANK;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_V_BLANK: begin
        if (phase_q == PW'(V_BLANK - 1)) begin
          phase_d = '0;
          if (en) begin
            state_d = S_FV_LEAD;
            col_d   = '0;
            line_d  = '0;
            pat_d   = pattern;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign col_ext  = DW'(col_d);
  assign line_ext = DW'(line_d);

  // Test pattern for the pixel being entered; frame_count is stable for the whole frame
  always_comb begin
    pixel_d = '0;
    unique case (pat_d)
      2'd0: pixel_d = col_ext;
      2'd1: pixel_d = line_ext;
      2'd2: pixel_d = (col_ext[3] ^ line_ext[3]) ? 10'h3FF : 10'h000;
      2'd3: pixel_d = col_ext + line_ext + frame_count;
      default: pixel_d = '0;
    endcase
  end

  // Output decode from the state being entered
  always_comb begin
    fv_d   = 1'b0;
    lv_d   = 1'b0;
    data_d = '0;
    unique case (state_d)
      S_FV_LEAD, S_H_BLANK, S_FV_TRAIL: fv_d = 1'b1;
      S_ACTIVE: begin
        fv_d   = 1'b1;
        lv_d   = 1'b1;
        data_d = pixel_d;
      end
      default: fv_d = 1'b0;
    endcase
    done_d = (state_q == S_FV_TRAIL) && (state_d == S_V_BLANK);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      line_valid  <= 1'b0;
      data_out    <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_valid <= fv_d;
      line_valid  <= lv_d;
      data_out    <= data_d;
      frame_done  <= done_d;
      if (done_d) frame_count <= frame_count + 10'd1;
    end
  end

endmodule

// File: tb/tb_camera_sensor_emulator.sv
// Bench for camera_sensor_emulator: frame-timeline model checked every cycle,
// a capture-side monitor, and directed plus randomized stimulus.
module tb_camera_sensor_emulator;

  localparam int unsigned TH     = 8;
  localparam int unsigned TV     = 4;
  localparam int unsigned THB    = 3;
  localparam int unsigned TLEAD  = 2;
  localparam int unsigned TTRAIL = 2;
  localparam int unsigned TVB    = 5;
  localparam int LINE_P = TH + THB;
  localparam int SPAN   = TV * TH + (TV - 1) * THB;
  localparam int FV_LEN = TLEAD + SPAN + TTRAIL;
  localparam int PERIOD = FV_LEN + TVB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic       frame_valid, line_valid, frame_done;
  logic [9:0] data_out, frame_count;

  int errors = 0;
  int checks = 0;

  camera_sensor_emulator #(
    .H(TH), .V(TV), .H_BLANK(THB), .FV_LEAD(TLEAD), .FV_TRAIL(TTRAIL), .V_BLANK(TVB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern(pattern),
    .frame_valid(frame_valid), .line_valid(line_valid), .data_out(data_out),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] pix(input int c, input int l, input int f, input logic [1:0] p);
    case (p)
      2'd0: return 10'(c);
      2'd1: return 10'(l);
      2'd2: return ((((c >> 3) ^ (l >> 3)) & 1) != 0) ? 10'd1023 : 10'd0;
      default: return 10'((c + l + f) % 1024);
    endcase
  endfunction

  // Reference model: position within the frame period timeline
  logic       m_run = 1'b0;
  int         m_t = 0;
  int         m_cnt = 0;
  logic [1:0] m_pat = 2'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_t <= 0; m_cnt <= 0; m_pat <= 2'd0;
    end else if (!m_run) begin
      if (en) begin m_run <= 1'b1; m_t <= 0; m_pat <= pattern; end
    end else if (m_t == PERIOD - 1) begin
      if (en) begin m_t <= 0; m_pat <= pattern; end
      else m_run <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == FV_LEN) m_cnt <= (m_cnt + 1) % 1024;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int u;
    logic e_fv, e_lv, e_done;
    logic [9:0] e_data;
    u      = m_t - TLEAD;
    e_fv   = m_run && (m_t < FV_LEN);
    e_lv   = m_run && (m_t >= TLEAD) && (u < SPAN) && ((u % LINE_P) < TH);
    e_data = e_lv ? pix(u % LINE_P, u / LINE_P, m_cnt, m_pat) : 10'd0;
    e_done = m_run && (m_t == FV_LEN);
    chk("model_fv", 32'(frame_valid), 32'(e_fv));
    chk("model_lv", 32'(line_valid), 32'(e_lv));
    chk("model_data", 32'(data_out), 32'(e_data));
    chk("model_done", 32'(frame_done), 32'(e_done));
    chk("model_count", 32'(frame_count), 32'(m_cnt));
  end

  // Capture-side monitor: samples on the rising edge like the real capture block
  logic fv_p = 1'b0, lv_p = 1'b0;
  int cyc = 0, last_rise = 0, last_period = 0;
  int fv_len = 0, lvp = 0, npix = 0, cl = 0, cc = 0, gap = 0;
  int frames_started = 0, frames_ended = 0, done_total = 0;
  int col_err = 0, gap_err = 0;
  int last_fv_len = 0, last_lvp = 0, last_pix = 0, last_lines = 0;
  logic [9:0] pix_arr [TV][TH];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    fv_p <= frame_valid;
    lv_p <= line_valid;
    if (frame_done) done_total <= done_total + 1;
    if (frame_valid && !fv_p) begin
      fv_len <= 1; lvp <= 0; npix <= 0; cl <= 0; cc <= 0; gap <= 0;
      frames_started <= frames_started + 1;
      last_period <= cyc - last_rise;
      last_rise <= cyc;
    end else if (frame_valid) begin
      fv_len <= fv_len + 1;
    end
    if (line_valid) begin
      npix <= npix + 1;
      if (!lv_p) begin
        lvp <= lvp + 1;
        if (lvp != 0 && gap != THB) gap_err <= gap_err + 1;
        if (cl < TV) pix_arr[cl][0] <= data_out;
        cc <= 1;
      end else begin
        if (cl < TV && cc < TH) pix_arr[cl][cc] <= data_out;
        cc <= cc + 1;
      end
    end
    if (lv_p && !line_valid) begin
      if (cc != TH) col_err <= col_err + 1;
      cl <= cl + 1;
      gap <= 1;
    end else if (frame_valid && !line_valid) begin
      gap <= gap + 1;
    end
    if (fv_p && !frame_valid) begin
      frames_ended <= frames_ended + 1;
      last_fv_len <= fv_len; last_lvp <= lvp; last_pix <= npix; last_lines <= cl;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_frame_end(input int budget);
    int b0;
    bit hit;
    b0 = frames_ended;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (frames_ended != b0) begin hit = 1'b1; break; end
    end
    if (!hit) chk("timeout_frame_end", 32'd0, 32'd1);
  endtask

  // which: 0 = frame_valid, 1 = line_valid
  task automatic wait_rise(input int which, input int budget);
    logic prev, cur;
    bit hit;
    prev = (which == 0) ? frame_valid : line_valid;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      cur = (which == 0) ? frame_valid : line_valid;
      if (cur && !prev) begin hit = 1'b1; break; end
      prev = cur;
    end
    if (!hit) chk("timeout_rise", 32'(which), 32'hFFFF);
  endtask

  task automatic wait_count(input int target, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (int'(frame_count) == target) begin hit = 1'b1; break; end
    end
    if (!hit) chk("timeout_count", 32'(frame_count), 32'(target));
  endtask

  initial begin
    int bad, d0, s0, ce0, ge0;
    logic [9:0] ex;

    // Reset and idle
    steps(3);
    rst_n = 1'b1;
    steps(20);
    chk("idle_fv", 32'(frame_valid), 32'd0);
    chk("idle_lv", 32'(line_valid), 32'd0);
    chk("idle_data", 32'(data_out), 32'd0);
    chk("idle_done_pulses", 32'(done_total), 32'd0);
    chk("idle_count", 32'(frame_count), 32'd0);

    // Single frame, pattern 0
    d0 = done_total;
    pattern = 2'd0;
    en = 1'b1;
    step();
    en = 1'b0;
    wait_frame_end(200);
    chk("single_fv_len", 32'(last_fv_len), 32'd45);
    chk("single_lv_pulses", 32'(last_lvp), 32'd4);
    chk("single_col_err", 32'(col_err), 32'd0);
    chk("single_gap_err", 32'(gap_err), 32'd0);
    bad = 0;
    for (int l = 0; l < TV; l++)
      for (int c = 0; c < TH; c++)
        if (pix_arr[l][c] !== 10'(c)) bad++;
    chk("single_p0_data_bad", 32'(bad), 32'd0);
    chk("single_done_pulses", 32'(done_total - d0), 32'd1);
    chk("single_count", 32'(frame_count), 32'd1);
    s0 = frames_started;
    steps(TVB + 10);
    chk("single_back_idle_fv", 32'(frame_valid), 32'd0);
    chk("single_no_restart", 32'(frames_started - s0), 32'd0);

    // Pattern latched at frame start, mid-frame change ignored
    pattern = 2'd1;
    en = 1'b1;
    wait_rise(0, 20);
    wait_rise(1, 20);
    wait_rise(1, 20);
    pattern = 2'd2;
    wait_frame_end(200);
    bad = 0;
    for (int l = 0; l < TV; l++)
      for (int c = 0; c < TH; c++)
        if (pix_arr[l][c] !== 10'(l)) bad++;
    chk("latch_p1_data_bad", 32'(bad), 32'd0);
    wait_rise(0, 40);
    en = 1'b0;
    wait_frame_end(200);
    bad = 0;
    for (int l = 0; l < TV; l++)
      for (int c = 0; c < TH; c++) begin
        ex = ((((c >> 3) ^ (l >> 3)) & 1) != 0) ? 10'd1023 : 10'd0;
        if (pix_arr[l][c] !== ex) bad++;
        if (pix_arr[l][c] !== 10'd0 && pix_arr[l][c] !== 10'd1023) bad++;
      end
    chk("latch_p2_checker_bad", 32'(bad), 32'd0);
    steps(TVB + 5);

    // EN dropped mid-frame: frame completes, then idle
    pattern = 2'd0;
    en = 1'b1;
    wait_rise(0, 20);
    wait_rise(1, 20);
    en = 1'b0;
    wait_frame_end(200);
    chk("endrop_fv_len", 32'(last_fv_len), 32'd45);
    chk("endrop_lv_pulses", 32'(last_lvp), 32'd4);
    s0 = frames_started;
    steps(TVB + 10);
    chk("endrop_no_restart", 32'(frames_started - s0), 32'd0);
    chk("endrop_idle_fv", 32'(frame_valid), 32'd0);

    // Reset mid-line truncates the frame without FRAME_DONE
    pattern = 2'd1;
    en = 1'b1;
    wait_rise(0, 20);
    wait_rise(1, 20);
    wait_rise(1, 20);
    steps(2);
    chk("midline_lv_before_rst", 32'(line_valid), 32'd1);
    d0 = done_total;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("rst_fv_immediate", 32'(frame_valid), 32'd0);
    chk("rst_lv_immediate", 32'(line_valid), 32'd0);
    chk("rst_data_immediate", 32'(data_out), 32'd0);
    steps(2);
    rst_n = 1'b1;
    step();
    chk("rst_no_done", 32'(done_total - d0), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    pattern = 2'd0;
    en = 1'b1;
    step();
    en = 1'b0;
    chk("restart_fv", 32'(frame_valid), 32'd1);
    chk("restart_lead_lv", 32'(line_valid), 32'd0);
    steps(TLEAD);
    chk("restart_lv", 32'(line_valid), 32'd1);
    chk("restart_col0", 32'(data_out), 32'd0);
    wait_frame_end(200);
    chk("restart_fv_len", 32'(last_fv_len), 32'd45);
    steps(TVB + 5);

    // Continuous frames with pattern 3 and loopback capture counts
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    ce0 = col_err;
    ge0 = gap_err;
    pattern = 2'd3;
    en = 1'b1;
    wait_count(2, 300);
    wait_rise(0, 20);
    wait_rise(1, 20);
    wait_rise(1, 20);
    steps(2);
    chk("cont_f2_l1_c2", 32'(data_out), 32'd5);
    chk("cont_fv_period", 32'(last_period), 32'd50);
    wait_frame_end(200);
    chk("loop_pixels", 32'(last_pix), 32'd32);
    chk("loop_lines", 32'(last_lines), 32'd4);
    chk("loop_col_err", 32'(col_err - ce0), 32'd0);
    chk("loop_gap_err", 32'(gap_err - ge0), 32'd0);

    // Randomized enable, pattern and occasional reset, checked by the model
    for (int i = 0; i < 3000; i++) begin
      step();
      en = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) pattern = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end

    en = 1'b0;
    steps(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
